countdown_sequencer: RTL and testbench

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/countdown_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: MM:SS BCD countdown timer driven by a 1 Hz tick.
// One decrement ripples through the digits one per clock, using a single
// shared 4-bit subtractor, so a tick costs 1 to 4 STEP cycles.
//
// Control inputs are one-cycle strobes with no handshake: each of load,
// start, pause and tick is acted on at the rising edge where it is high and
// never stalls. Same-cycle priority is reset > load > pause > start > tick.
// A tick that cannot be served (arrives while a step is rippling) is
// dropped and reported on overrun.

// Shared 4-bit subtractor: minuend - subtrahend via two's complement add.
// carry=1 means no borrow, carry=0 means the minuend was smaller.
module countdown_sub4 (
    input  logic [3:0] minuend,
    input  logic [3:0] subtrahend,
    output logic [3:0] difference,
    output logic       carry
);
    logic [4:0] sum;

    assign sum        = {1'b0, minuend} + {1'b0, ~subtrahend} + 5'd1;
    assign difference = sum[3:0];
    assign carry      = sum[4];
endmodule

module countdown_sequencer #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic        tick,
    output logic [15:0] digits,
    output logic        running,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] digits_q, digits_d;
    logic        pause_pend_q, pause_pend_d;
    logic        running_q, running_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic [3:0]  sub_minuend;
    logic [3:0]  sub_diff;
    logic        sub_carry;
    logic [3:0]  wrap_val;
    logic [15:0] step_digits;

    // Clamp each loaded digit to its legal maximum.
    function automatic logic [15:0] saturate(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0]   > 4'd9)         r[3:0]   = 4'd9;
        if (v[7:4]   > SEC_TENS_MAX) r[7:4]   = SEC_TENS_MAX;
        if (v[11:8]  > 4'd9)         r[11:8]  = 4'd9;
        if (v[15:12] > 4'd9)         r[15:12] = 4'd9;
        return r;
    endfunction

    // The one subtractor in the design; the digit selected by idx feeds it.
    countdown_sub4 u_sub (
        .minuend    (sub_minuend),
        .subtrahend (4'd1),
        .difference (sub_diff),
        .carry      (sub_carry)
    );

    // Select the digit being visited and the value it wraps to on borrow.
    always_comb begin
        sub_minuend = digits_q[{idx_q, 2'b00} +: 4];
        wrap_val    = (idx_q == 2'd1) ? SEC_TENS_MAX : 4'd9;
    end

    // Digits after this STEP cycle's write: difference, or wrap on borrow.
    always_comb begin
        step_digits = digits_q;
        step_digits[{idx_q, 2'b00} +: 4] = sub_carry ? sub_diff : wrap_val;
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        digits_d     = digits_q;
        pause_pend_d = pause_pend_q;
        overrun_d    = 1'b0;

        if (load) begin
            // load wins over everything but reset and aborts any ripple.
            digits_d     = saturate(load_value);
            state_d      = ST_IDLE;
            idx_d        = 2'd0;
            pause_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (digits_q != 16'h0000) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        state_d = ST_STEP;
                        idx_d   = 2'd0;
                    end
                end
                ST_STEP: begin
                    // A tick here cannot be served; drop it and flag it.
                    overrun_d = tick;
                    digits_d  = step_digits;
                    if (sub_carry) begin
                        // Ripple finished on this digit.
                        idx_d        = 2'd0;
                        pause_pend_d = 1'b0;
                        if (step_digits == 16'h0000) begin
                            state_d = ST_DONE;
                        end else if (pause_pend_q || pause) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (idx_q == 2'd3) begin
                        // Borrow out of the top digit: only reachable if
                        // STEP was entered at zero; clamp to 00:00.
                        digits_d     = 16'h0000;
                        idx_d        = 2'd0;
                        pause_pend_d = 1'b0;
                        state_d      = ST_DONE;
                    end else begin
                        // Borrow: keep rippling into the next digit.
                        idx_d        = idx_q + 2'd1;
                        pause_pend_d = pause_pend_q | pause;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags are registered copies of the state being entered.
        running_d = (state_d == ST_RUN) || (state_d == ST_STEP);
        busy_d    = (state_d == ST_STEP);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            digits_q     <= 16'h0000;
            pause_pend_q <= 1'b0;
            running_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            digits_q     <= digits_d;
            pause_pend_q <= pause_pend_d;
            running_q    <= running_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign digits      = digits_q;
    assign running     = running_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Testbench for countdown_sequencer: a driver issues load/start/pause/tick
// operations and pushes expected events into exp_q from a seconds-based
// reference model; a negedge monitor pops and compares every overrun pulse,
// end of a STEP ripple and done pulse the DUT presents.
module tb_countdown_sequencer;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam int         SEC_RADIX    = (int'(SEC_TENS_MAX) + 1) * 10;
    localparam logic [1:0] EV_OVR       = 2'd1;
    localparam logic [1:0] EV_STEP      = 2'd2;
    localparam logic [1:0] EV_DONE      = 2'd3;
    localparam int         EW           = 21;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [1:0]  dbg_state;

    // Expected events: {kind[1:0], ripple length[2:0], digits[15:0]}.
    logic [EW-1:0] exp_q[$];

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [15:0] m_val = 16'h0000;
    bit          m_run = 1'b0;
    int          busy_len = 0;
    bit          prev_busy = 1'b0;

    countdown_sequencer #(.SEC_TENS_MAX(SEC_TENS_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .pause       (pause),
        .tick        (tick),
        .digits      (digits),
        .running     (running),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (time in seconds) ----------------
    function automatic logic [15:0] sat_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0]   > 4'd9)         r[3:0]   = 4'd9;
        if (v[7:4]   > SEC_TENS_MAX) r[7:4]   = SEC_TENS_MAX;
        if (v[11:8]  > 4'd9)         r[11:8]  = 4'd9;
        if (v[15:12] > 4'd9)         r[15:12] = 4'd9;
        return r;
    endfunction

    function automatic int to_secs(input logic [15:0] b);
        int mins;
        int secs;
        mins = int'(b[15:12]) * 10 + int'(b[11:8]);
        secs = int'(b[7:4]) * 10 + int'(b[3:0]);
        return mins * SEC_RADIX + secs;
    endfunction

    function automatic logic [15:0] from_secs(input int t);
        int m;
        int s;
        m = t / SEC_RADIX;
        s = t % SEC_RADIX;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Ripple length = position of the highest digit that changes.
    function automatic int ripple_len(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i*4 +: 4] != b[i*4 +: 4]) n = i + 1;
        end
        return n;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input int len, input logic [15:0] d);
        exp_q.push_back({kind, 3'(len), d});
    endtask

    task automatic expect_event(input logic [1:0] kind, input int len, input logic [15:0] d);
        logic [EW-1:0] e;
        chk_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_event: got kind=%0d len=%0d digits=%h, expected no event",
                     kind, len, d);
            return;
        end
        e = exp_q.pop_front();
        if (e[20:19] != kind ||
            (kind == EV_STEP && (int'(e[18:16]) != len || e[15:0] != d))) begin
            err_cnt++;
            $display("FAIL event: got kind=%0d len=%0d digits=%h, expected kind=%0d len=%0d digits=%h",
                     kind, len, d, e[20:19], e[18:16], e[15:0]);
        end
    endtask

    // Monitor: pops an expected event for every observable DUT event.
    always @(negedge clk) begin
        if (reset) begin
            busy_len  = 0;
            prev_busy = 1'b0;
        end else begin
            if (overrun === 1'b1) expect_event(EV_OVR, 0, 16'h0000);
            if (prev_busy && busy === 1'b0) expect_event(EV_STEP, busy_len, digits);
            if (done === 1'b1) expect_event(EV_DONE, 0, 16'h0000);
            busy_len  = (busy === 1'b1) ? busy_len + 1 : 0;
            prev_busy = (busy === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'(m_val));
        check({tag, "_running"}, 32'(running), 32'(m_run));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load = 1'b1;
        step_clk(1);
        load = 1'b0;
        load_value = 16'($urandom);
        m_val = sat_bcd(v);
        m_run = 1'b0;
        step_clk(2);
        quiet_check("load");
    endtask

    task automatic do_start();
        start = 1'b1;
        step_clk(1);
        start = 1'b0;
        if (!m_run) begin
            if (m_val == 16'h0000) push(EV_DONE, 0, 16'h0000);
            else m_run = 1'b1;
        end
        step_clk(3);
        quiet_check("start");
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step_clk(1);
        pause = 1'b0;
        m_run = 1'b0;
        step_clk(2);
        quiet_check("pause");
    endtask

    // One tick; optionally a second tick and/or a pause on STEP cycle k.
    task automatic do_tick(input int ovr_at, input int pause_at);
        int          len;
        int          o;
        int          p;
        logic [15:0] nv;
        o = ovr_at;
        p = pause_at;
        tick = 1'b1;
        step_clk(1);
        tick = 1'b0;
        if (m_run) begin
            nv  = from_secs(to_secs(m_val) - 1);
            len = ripple_len(m_val, nv);
            if (o > len) o = 0;
            if (o != 0) push(EV_OVR, 0, 16'h0000);
            push(EV_STEP, len, nv);
            if (nv == 16'h0000) push(EV_DONE, 0, 16'h0000);
            if (nv == 16'h0000 || p != 0) m_run = 1'b0;
            m_val = nv;
        end else begin
            o = 0;
            p = 0;
        end
        for (int k = 1; k <= 5; k++) begin
            if (k == o) tick = 1'b1;
            if (k == p) pause = 1'b1;
            step_clk(1);
            tick  = 1'b0;
            pause = 1'b0;
        end
        step_clk(2);
        quiet_check("tick");
    endtask

    // Tick, then load v on STEP cycle k (k must not exceed the ripple).
    task automatic do_load_mid_step(input logic [15:0] v, input int k);
        tick = 1'b1;
        step_clk(1);
        tick = 1'b0;
        step_clk(k - 1);
        load_value = v;
        load = 1'b1;
        push(EV_STEP, k, sat_bcd(v));
        step_clk(1);
        load = 1'b0;
        m_val = sat_bcd(v);
        m_run = 1'b0;
        step_clk(2);
        quiet_check("abort_load");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          op;
        logic [15:0] v;

        // Reset state.
        step_clk(2);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        step_clk(1);

        // Ticks before any start are ignored.
        do_load(16'h0005);
        do_tick(0, 0);

        // 01:30 -> 01:29 in a two-digit ripple.
        do_load(16'h0130);
        do_start();
        do_tick(0, 0);
        check("ripple2_digits", 32'(digits), 32'h0129);

        // 10:00 -> 09:59, full ripple, no done.
        do_load(16'h1000);
        do_start();
        do_tick(0, 0);
        check("ripple4_digits", 32'(digits), 32'h0959);

        // 00:02 counts to zero, one done, then ticks have no effect.
        do_load(16'h0002);
        do_start();
        do_tick(0, 0);
        do_tick(0, 0);
        do_tick(0, 0);

        // Second tick dropped mid ripple, and on the last ripple cycle.
        do_load(16'h1000);
        do_start();
        do_tick(2, 0);
        check("overrun_digits", 32'(digits), 32'h0959);
        do_load(16'h0130);
        do_start();
        do_tick(2, 0);

        // Saturation and start at zero.
        do_load(16'hFFFF);
        check("sat_digits", 32'(digits), 32'h9959);
        do_load(16'h0000);
        do_start();

        // Pause during a ripple: step completes, then idle.
        do_load(16'h1000);
        do_start();
        do_start();
        do_tick(0, 2);
        do_tick(0, 0);
        do_start();
        do_pause();
        do_tick(0, 0);

        // Load aborts a ripple.
        do_load(16'h1000);
        do_start();
        do_load_mid_step(16'h0042, 2);

        // Reset on the second STEP cycle of a 10:00 decrement.
        do_load(16'h1000);
        do_start();
        tick = 1'b1;
        step_clk(1);
        tick = 1'b0;
        step_clk(1);
        reset = 1'b1;
        step_clk(1);
        check("rst_mid_digits", 32'(digits), 32'h0);
        check("rst_mid_running", 32'(running), 32'h0);
        step_clk(1);
        reset = 1'b0;
        m_val = 16'h0000;
        m_run = 1'b0;
        step_clk(1);
        do_tick(0, 0);

        // Randomized operations.
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: begin
                    if ($urandom_range(0, 1) == 1) v = 16'($urandom);
                    else v = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 4))};
                    do_load(v);
                end
                1, 2: do_start();
                3, 4: do_tick(0, 0);
                5: do_tick($urandom_range(1, 4), 0);
                6: do_tick(0, $urandom_range(1, 5));
                default: begin
                    if ($urandom_range(0, 3) == 0) do_pause();
                    else do_tick(0, 0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
